// File: rtl/stlb_pkg.sv
// Shared types and defaults for the STLB request controller.
package stlb_pkg;

  localparam int DEF_SADDR = 64;
  localparam int DEF_SPAGE = 12;
  localparam int DEF_SPCID = 12;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WAIT,
    ST_WALK,
    ST_INSERT,
    ST_RESP,
    ST_FLUSH
  } stlb_ctrl_state_t;

endpackage

// File: rtl/stlb_rr_arb.sv
// Two-way round-robin arbiter: rr names the port favoured when both request.
module stlb_rr_arb
  import stlb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (rr == PORT_D) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/stlb_ctrl.sv
// STLB request controller: arbitrates ITLB/DTLB misses, sequences lookup/walk/insert/response, serializes flushes.
// Define STLB_CTRL_PERF_EN to add saturating perf_hit/perf_miss counters.
module stlb_ctrl
  import stlb_pkg::*;
#(
  parameter int SADDR = DEF_SADDR,
  parameter int SPAGE = DEF_SPAGE,
  parameter int SPCID = DEF_SPCID
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*SADDR-1:0]   req_va,
  input  logic [2*SPCID-1:0]   req_pcid,
  output logic [1:0]           rsp_valid,
  output logic [SADDR-1:0]     rsp_pa,
  output logic                 rsp_fault,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 stlb_lookup,
  output logic [SADDR-1:0]     stlb_va,
  output logic [SPCID-1:0]     stlb_pcid,
  input  logic                 stlb_hit,
  input  logic                 stlb_miss,
  input  logic [SADDR-1:0]     stlb_ta,
  output logic                 stlb_insert,
  output logic [SADDR-1:0]     stlb_pa,
  output logic                 stlb_shutdown,
  output logic                 walk_valid,
  output logic [SADDR-1:0]     walk_va,
  output logic [SPCID-1:0]     walk_pcid,
  input  logic                 walk_done,
  input  logic [SADDR-1:0]     walk_pa,
`ifdef STLB_CTRL_PERF_EN
  output logic [31:0]          perf_hit,
  output logic [31:0]          perf_miss,
`endif
  input  logic                 walk_fault
);

  stlb_ctrl_state_t state;
  logic [1:0]       grant;
  logic             gidx;
  logic             owner;
  logic             rr;
  logic [SADDR-1:0] va;
  logic [SPCID-1:0] pcid;
  logic [SADDR-1:0] page_mask;
  logic [SADDR-1:0] ins_pa;

  function automatic logic [1:0] port_onehot(input logic p);
    return (p == PORT_D) ? 2'b10 : 2'b01;
  endfunction

  stlb_rr_arb u_arb (
    .valid (req_valid),
    .rr    (rr),
    .grant (grant)
  );

  assign gidx      = grant[1];
  assign req_ready = (state == ST_IDLE && !flush_req) ? grant : 2'b00;

  // Physical page from the walker, page offset from the original VA.
  assign page_mask = {{(SADDR-SPAGE){1'b0}}, {SPAGE{1'b1}}};
  assign ins_pa    = (walk_pa & ~page_mask) | (va & page_mask);

  assign stlb_va   = va;
  assign stlb_pcid = pcid;
  assign walk_va   = va;
  assign walk_pcid = pcid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr            <= PORT_I;
      owner         <= PORT_I;
      va            <= '0;
      pcid          <= '0;
      rsp_valid     <= 2'b00;
      rsp_pa        <= '0;
      rsp_fault     <= 1'b0;
      flush_done    <= 1'b0;
      stlb_lookup   <= 1'b0;
      stlb_insert   <= 1'b0;
      stlb_pa       <= '0;
      stlb_shutdown <= 1'b0;
      walk_valid    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            stlb_shutdown <= 1'b1;
            flush_done    <= 1'b1;
            state         <= ST_FLUSH;
          end else if (|grant) begin
            owner       <= gidx;
            va          <= gidx ? req_va[2*SADDR-1:SADDR] : req_va[SADDR-1:0];
            pcid        <= gidx ? req_pcid[2*SPCID-1:SPCID] : req_pcid[SPCID-1:0];
            stlb_lookup <= 1'b1;
            state       <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          stlb_lookup <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          if (stlb_hit) begin
            rsp_pa    <= stlb_ta;
            rsp_fault <= 1'b0;
            rsp_valid <= port_onehot(owner);
            state     <= ST_RESP;
          end else if (stlb_miss) begin
            walk_valid <= 1'b1;
            state      <= ST_WALK;
          end
        end
        ST_WALK: begin
          if (walk_done) begin
            walk_valid <= 1'b0;
            if (walk_fault) begin
              rsp_fault <= 1'b1;
              rsp_pa    <= '0;
              rsp_valid <= port_onehot(owner);
              state     <= ST_RESP;
            end else begin
              stlb_insert <= 1'b1;
              stlb_pa     <= ins_pa;
              state       <= ST_INSERT;
            end
          end
        end
        ST_INSERT: begin
          stlb_insert <= 1'b0;
          rsp_pa      <= stlb_pa;
          rsp_fault   <= 1'b0;
          rsp_valid   <= port_onehot(owner);
          state       <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid <= 2'b00;
          rr        <= ~owner;
          state     <= ST_IDLE;
        end
        ST_FLUSH: begin
          stlb_shutdown <= 1'b0;
          flush_done    <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef STLB_CTRL_PERF_EN
  logic hit_ev;
  logic miss_ev;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign hit_ev  = (state == ST_WAIT) && stlb_hit;
  assign miss_ev = (state == ST_WAIT) && !stlb_hit && stlb_miss;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if (state == ST_FLUSH) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (hit_ev)  perf_hit  <= sat_inc(perf_hit);
      if (miss_ev) perf_miss <= sat_inc(perf_miss);
    end
  end
`endif

endmodule

// File: tb/tb_stlb_ctrl.sv
// Self-checking bench for stlb_ctrl: directed scenarios plus randomized translations against a transaction-level model.
module tb_stlb_ctrl;

  localparam int SADDR = 64;
  localparam int SPAGE = 12;
  localparam int SPCID = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           req_valid = '0;
  logic [1:0]           req_ready;
  logic [2*SADDR-1:0]   req_va = '0;
  logic [2*SPCID-1:0]   req_pcid = '0;
  logic [1:0]           rsp_valid;
  logic [SADDR-1:0]     rsp_pa;
  logic                 rsp_fault;
  logic                 flush_req = 1'b0;
  logic                 flush_done;
  logic                 stlb_lookup;
  logic [SADDR-1:0]     stlb_va;
  logic [SPCID-1:0]     stlb_pcid;
  logic                 stlb_hit = 1'b0;
  logic                 stlb_miss = 1'b0;
  logic [SADDR-1:0]     stlb_ta = '0;
  logic                 stlb_insert;
  logic [SADDR-1:0]     stlb_pa;
  logic                 stlb_shutdown;
  logic                 walk_valid;
  logic [SADDR-1:0]     walk_va;
  logic [SPCID-1:0]     walk_pcid;
  logic                 walk_done = 1'b0;
  logic [SADDR-1:0]     walk_pa = '0;
  logic                 walk_fault = 1'b0;

  int   checks = 0;
  int   failures = 0;
  logic rr_m = 1'b0;

  stlb_ctrl #(.SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
    .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_fault(rsp_fault),
    .flush_req(flush_req), .flush_done(flush_done),
    .stlb_lookup(stlb_lookup), .stlb_va(stlb_va), .stlb_pcid(stlb_pcid),
    .stlb_hit(stlb_hit), .stlb_miss(stlb_miss), .stlb_ta(stlb_ta),
    .stlb_insert(stlb_insert), .stlb_pa(stlb_pa), .stlb_shutdown(stlb_shutdown),
    .walk_valid(walk_valid), .walk_va(walk_va), .walk_pcid(walk_pcid),
    .walk_done(walk_done), .walk_pa(walk_pa), .walk_fault(walk_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    flush_req = 1'b0;
    #1;
    step();
    rst = 1'b0;
    rr_m = 1'b0;
  endtask

  // One full translation; the model picks the owner from the rr rule and derives the expected PA.
  task automatic do_txn(input logic [1:0] vmask, input logic [63:0] va0, input logic [63:0] va1,
                        input logic [11:0] pc0, input logic [11:0] pc1, input bit hit, input int lk_lat,
                        input bit fault, input int wk_lat, input logic [63:0] ta, input logic [63:0] wpa);
    logic        own;
    logic [1:0]  oh;
    logic [63:0] eva;
    logic [63:0] epa;
    logic [11:0] epc;
    own = (vmask == 2'b11) ? rr_m : vmask[1];
    oh  = own ? 2'b10 : 2'b01;
    eva = own ? va1 : va0;
    epc = own ? pc1 : pc0;
    epa = hit ? ta : (fault ? 64'd0 : {wpa[63:SPAGE], eva[SPAGE-1:0]});
    req_valid = vmask;
    req_va    = {va1, va0};
    req_pcid  = {pc1, pc0};
    #1;
    checks++; if (req_ready !== oh) begin failures++; $display("FAIL grant: req_ready=%b expected %b", req_ready, oh); end
    step();
    checks++; if ({stlb_lookup, stlb_va, stlb_pcid} !== {1'b1, eva, epc}) begin failures++;
      $display("FAIL lookup: strobe=%b va=%h pcid=%h expected 1 %h %h", stlb_lookup, stlb_va, stlb_pcid, eva, epc); end
    step();
    checks++; if (stlb_lookup !== 1'b0) begin failures++; $display("FAIL lookup_pulse: stlb_lookup=%b expected 0", stlb_lookup); end
    repeat (lk_lat) step();
    stlb_ta   = ta;
    stlb_hit  = hit;
    stlb_miss = hit ? ($urandom_range(0, 1) == 1) : 1'b1;
    step();
    stlb_hit  = 1'b0;
    stlb_miss = 1'b0;
    if (!hit) begin
      checks++; if ({walk_valid, walk_va, walk_pcid} !== {1'b1, eva, epc}) begin failures++;
        $display("FAIL walk_req: valid=%b va=%h pcid=%h expected 1 %h %h", walk_valid, walk_va, walk_pcid, eva, epc); end
      for (int i = 0; i < wk_lat; i++) begin
        step();
        checks++; if (walk_valid !== 1'b1) begin failures++; $display("FAIL walk_hold: walk_valid=%b expected 1", walk_valid); end
      end
      walk_done  = 1'b1;
      walk_pa    = wpa;
      walk_fault = fault;
      step();
      walk_done  = 1'b0;
      walk_fault = 1'b0;
      checks++; if (walk_valid !== 1'b0) begin failures++; $display("FAIL walk_drop: walk_valid=%b expected 0", walk_valid); end
      if (!fault) begin
        checks++; if ({stlb_insert, stlb_pa, rsp_valid} !== {1'b1, epa, 2'b00}) begin failures++;
          $display("FAIL insert: strobe=%b pa=%h rsp_valid=%b expected 1 %h 00", stlb_insert, stlb_pa, rsp_valid, epa); end
        step();
      end
    end
    checks++; if ({rsp_valid, rsp_pa, rsp_fault, stlb_insert, walk_valid} !== {oh, epa, (!hit && fault), 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL response: rsp_valid=%b pa=%h fault=%b insert=%b walk=%b expected %b %h %b 0 0",
               rsp_valid, rsp_pa, rsp_fault, stlb_insert, walk_valid, oh, epa, (!hit && fault));
    end
    step();
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rsp_pulse: rsp_valid=%b expected 00", rsp_valid); end
    req_valid = '0;
    rr_m = ~own;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_pa, rsp_fault, flush_done, stlb_lookup, stlb_va, stlb_pcid, stlb_insert,
                   stlb_pa, stlb_shutdown, walk_valid, walk_va, walk_pcid} !== '0) begin failures++;
      $display("FAIL reset_outputs: some output nonzero during reset (rsp_valid=%b walk_valid=%b)", rsp_valid, walk_valid); end
    rst = 1'b0;
    rr_m = 1'b0;
    step();
    checks++; if ({rsp_valid, stlb_lookup, stlb_insert, stlb_shutdown, flush_done, walk_valid} !== 6'b0) begin failures++;
      $display("FAIL idle_after_reset: strobes active with no request"); end
  endtask

  task automatic test_hit();
    do_txn(2'b01, 64'h1234_5678, 64'h0, 12'd3, 12'd0, 1'b1, 0, 1'b0, 0, 64'hABCD_E678, 64'h0);
  endtask

  task automatic test_miss();
    do_txn(2'b10, 64'h0, 64'h7000_0ABC, 12'd0, 12'd9, 1'b0, 1, 1'b0, 4, 64'h0, 64'h5_5000);
  endtask

  task automatic test_fault();
    do_txn(2'b01, 64'hDEAD_B123, 64'h0, 12'd5, 12'd0, 1'b0, 0, 1'b1, 2, 64'h0, 64'hFFFF_F000);
    do_txn(2'b10, 64'h0, 64'h4444_4321, 12'd0, 12'd6, 1'b0, 2, 1'b1, 0, 64'h0, 64'h1_2000);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 12'd1, 12'd2, 1'b1, 0, 1'b0, 0,
             64'h8000_0000 + 64'(i), 64'h0);
    end
  endtask

  task automatic test_flush_mid_walk();
    req_valid = 2'b01;
    req_va    = {64'h0, 64'h3333_3ABC};
    req_pcid  = {12'd0, 12'd7};
    #1;
    step();
    step();
    stlb_miss = 1'b1;
    step();
    stlb_miss = 1'b0;
    flush_req = 1'b1;
    req_valid = 2'b10;
    req_va    = {64'h6666_6DEF, 64'h3333_3ABC};
    req_pcid  = {12'd11, 12'd7};
    step();
    checks++; if ({stlb_shutdown, flush_done, req_ready, walk_valid} !== 5'b00001) begin failures++;
      $display("FAIL flush_wait_walk: shutdown=%b done=%b ready=%b walk=%b expected 0 0 00 1",
               stlb_shutdown, flush_done, req_ready, walk_valid); end
    walk_done = 1'b1;
    walk_pa   = 64'h9_9000;
    step();
    walk_done = 1'b0;
    checks++; if ({stlb_shutdown, stlb_insert} !== 2'b01) begin failures++;
      $display("FAIL flush_wait_insert: shutdown=%b insert=%b expected 0 1", stlb_shutdown, stlb_insert); end
    step();
    checks++; if ({stlb_shutdown, rsp_valid} !== 3'b001) begin failures++;
      $display("FAIL flush_wait_resp: shutdown=%b rsp_valid=%b expected 0 01", stlb_shutdown, rsp_valid); end
    step();
    checks++; if ({stlb_shutdown, req_ready} !== 3'b000) begin failures++;
      $display("FAIL flush_priority: shutdown=%b req_ready=%b expected 0 00", stlb_shutdown, req_ready); end
    step();
    checks++; if ({stlb_shutdown, flush_done, req_ready} !== 4'b1100) begin failures++;
      $display("FAIL flush_pulse: shutdown=%b done=%b ready=%b expected 1 1 00", stlb_shutdown, flush_done, req_ready); end
    flush_req = 1'b0;
    step();
    checks++; if ({stlb_shutdown, flush_done, req_ready} !== 4'b0010) begin failures++;
      $display("FAIL flush_release: shutdown=%b done=%b ready=%b expected 0 0 10", stlb_shutdown, flush_done, req_ready); end
    req_valid = '0;
    rr_m = 1'b1;
    do_txn(2'b10, 64'h3333_3ABC, 64'h6666_6DEF, 12'd7, 12'd11, 1'b1, 0, 1'b0, 0, 64'hCAFE_0DEF, 64'h0);
  endtask

  task automatic test_reset_mid_walk();
    req_valid = 2'b10;
    req_va    = {64'h5555_5555, 64'h0};
    req_pcid  = {12'd4, 12'd0};
    #1;
    step();
    step();
    stlb_miss = 1'b1;
    step();
    stlb_miss = 1'b0;
    req_valid = '0;
    step();
    checks++; if (walk_valid !== 1'b1) begin failures++; $display("FAIL walk_before_reset: walk_valid=%b expected 1", walk_valid); end
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_pa, rsp_fault, flush_done, stlb_lookup, stlb_va, stlb_pcid, stlb_insert,
                   stlb_pa, stlb_shutdown, walk_valid, walk_va, walk_pcid} !== '0) begin failures++;
      $display("FAIL reset_mid_walk: outputs not cleared (walk_valid=%b rsp_valid=%b)", walk_valid, rsp_valid); end
    walk_done = 1'b1;
    walk_pa   = 64'hFFFF_0000;
    step();
    walk_done = 1'b0;
    step();
    rst = 1'b0;
    rr_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({rsp_valid, stlb_insert, walk_valid} !== 4'b0) begin failures++;
        $display("FAIL dropped_txn: rsp_valid=%b insert=%b walk=%b expected 00 0 0", rsp_valid, stlb_insert, walk_valid); end
    end
    do_txn(2'b11, 64'h1111_1AAA, 64'h2222_2BBB, 12'd1, 12'd2, 1'b0, 0, 1'b0, 1, 64'h0, 64'h77_7000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic [1:0] vm;
      bit         h;
      bit         f;
      vm = 2'($urandom_range(1, 3));
      h  = ($urandom_range(0, 1) == 1);
      f  = ($urandom_range(0, 2) == 0);
      do_txn(vm, {$urandom, $urandom}, {$urandom, $urandom}, 12'($urandom), 12'($urandom), h,
             int'($urandom_range(0, 3)), f, int'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom});
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss();
    test_fault();
    test_back_to_back();
    test_flush_mid_walk();
    test_reset_mid_walk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stlb_ctrl.md
# stlb_ctrl

Request controller in front of the shared second-level TLB (`stlb`). It arbitrates translation requests from the ITLB and DTLB miss paths using round-robin, and sequences each granted request: lookup, then a page-walk on miss, then insert, then response. It also serializes TLB flushes against in-flight translations. Sits between the L1 TLBs, the `stlb` array and the page walker.

## Interface
Parameters:
- `SADDR`, 64, address width
- `SPAGE`, 12, page-offset width
- `SPCID`, 12, PCID width

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 2: request valid; [0] = ITLB, [1] = DTLB.
- `req_ready` out 2: request accepted when `valid & ready`.
- `req_va` in 2*SADDR: per-port virtual address; port p at [p*SADDR +: SADDR].
- `req_pcid` in 2*SPCID: per-port PCID, same packing as `req_va`.
- `rsp_valid` out 2: one-cycle response pulse to the owning port.
- `rsp_pa` out SADDR: translated address.
- `rsp_fault` out 1: walk fault; `rsp_pa` is 0 when set.
- `flush_req` in 1: level; held until `flush_done`.
- `flush_done` out 1: one-cycle pulse.
- `stlb_lookup` out 1: lookup strobe.
- `stlb_va` out SADDR: lookup/insert VA.
- `stlb_pcid` out SPCID: lookup/insert PCID.
- `stlb_hit`, `stlb_miss` in 1 each: lookup result.
- `stlb_ta` in SADDR: hit address.
- `stlb_insert` out 1: insert strobe.
- `stlb_pa` out SADDR: insert PA.
- `stlb_shutdown` out 1: clear all entries.
- `walk_valid` out 1: walk request.
- `walk_va` out SADDR: walk VA.
- `walk_pcid` out SPCID: walk PCID.
- `walk_done` in 1: walk complete.
- `walk_pa` in SADDR: walk result.
- `walk_fault` in 1: walk fault.

## Operation
States: IDLE, LOOKUP, WAIT, WALK, INSERT, RESP, FLUSH.

- **IDLE**
  - `flush_req` has priority: go to FLUSH, `req_ready` = 0.
  - Otherwise grant the valid port favoured by the rr pointer; if only one port is valid, grant it.
  - `req_ready` is combinational and high only for the granted port.
  - Latch VA, PCID and owner; go to LOOKUP.
- **LOOKUP**: `stlb_lookup` = 1 for one cycle with latched `stlb_va`/`stlb_pcid`; go to WAIT.
- **WAIT**: hold until `stlb_hit` or `stlb_miss`.
  - Hit wins if both are high.
  - Hit: capture `stlb_ta`, go to RESP.
  - Miss: go to WALK.
- **WALK**: `walk_valid`, `walk_va` and `walk_pcid` are held until `walk_done`. `walk_done` in the first WALK cycle is legal.
  - Fault: `rsp_fault` = 1, `rsp_pa` = 0, go to RESP with no insert.
  - No fault: capture `walk_pa`, go to INSERT.
- **INSERT**: `stlb_insert` = 1 for one cycle with `stlb_pa` = {walk_pa[SADDR-1:SPAGE], va[SPAGE-1:0]}; go to RESP.
- **RESP**: `rsp_valid[owner]` = 1 for one cycle; `rr` <= ~owner; go to IDLE.
- **FLUSH**: `stlb_shutdown` = 1 and `flush_done` = 1 for one cycle; go to IDLE. A flush arriving mid-translation waits until IDLE.

Reset:
- All outputs 0, state IDLE, `rr` = 0.
- Reset mid-walk drops the transaction with no response; `walk_valid` falls immediately.

## Timing
- Hit: accept at T, `stlb_lookup` at T+1, earliest hit at T+2, `rsp_valid` at T+3.
- Miss with `walk_done` at cycle W: `stlb_insert` at W+1, `rsp_valid` at W+2.
- Miss with fault at W: `rsp_valid` at W+1.
- Back-to-back: the next grant is at the cycle after RESP, giving at most one translation per 4 cycles.
- Flush: `flush_req` seen in IDLE at F, `stlb_shutdown`/`flush_done` at F+1.
- All strobes are single-cycle and registered. Only `req_ready` is combinational.

## Configuration
- `STLB_CTRL_PERF_EN` defined:
  - Adds outputs `perf_hit` and `perf_miss`, 32 bits each, saturating at 0xFFFFFFFF.
  - `perf_hit` increments on a WAIT-state hit; `perf_miss` on a WAIT-state miss.
  - Both clear on `rst` and on FLUSH.
- `STLB_CTRL_PERF_EN` undefined: the ports and counters are absent.

## Structure
- Package `stlb_pkg` holds the state enum `stlb_ctrl_state_t`, the port IDs `PORT_I`/`PORT_D`, and the default widths SADDR/SPAGE/SPCID.
- Sub-module `stlb_rr_arb`: 2-way round-robin arbiter taking `valid[1:0]` and `rr`, giving a one-hot `grant`.

## Test plan
- Port 0 requests VA 0x1234_5678, PCID 3; `stlb_hit` with `stlb_ta` 0xABCD_E678 → `rsp_valid[0]` at T+3, `rsp_pa` 0xABCD_E678, no walk.
- Port 1 requests VA 0x7000_0ABC; `stlb_miss`; `walk_done` after 5 cycles with `walk_pa` 0x5_5000 → `stlb_insert` with `stlb_pa` 0x5_5ABC, then `rsp_valid[1]`.
- Both ports request continuously → grants alternate 0, 1, 0, 1 starting with port 0 after reset.
- `walk_fault` = 1 → `rsp_fault` = 1, `rsp_pa` = 0, `stlb_insert` never asserted.
- `flush_req` raised during WALK → `stlb_shutdown` only after RESP, one cycle, with `flush_done` alongside; a pending port request waits until after the flush.
- `rst` pulsed during WALK → all outputs 0 next cycle, no `rsp_valid`; a new request is then served normally.
